conv1d_stream_param: RTL and testbench
======================================

# conv1d_stream_param

Parametrised streaming 1-D convolution engine, successor to the fixed 32-tap-input / 6-tap-filter convolution blocks produced by the hardware generation flow. Width, input length, filter length and stride are set by parameters. Filter coefficients are loaded at run time over a handshake port, so no per-configuration ROM is generated. The block sits between an upstream x-vector source and a downstream consumer, and uses valid/ready handshakes on all streams.

## Interface
- `WIDTH`, 16: signed data and coefficient width.
- `X`, 32: input vector length; must be at least `F`.
- `F`, 6: filter length; must be at least 2.
- `STRIDE`, 1: output step; `(X-F) % STRIDE == 0` is required. Output count is `N = (X-F)/STRIDE + 1`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `f_data` in `WIDTH`: signed filter coefficient.
- `f_valid` in 1 / `f_ready` out 1: filter load handshake.
- `x_data` in `WIDTH`: signed input sample.
- `x_valid` in 1 / `x_ready` out 1: input handshake.
- `y_data` out `WIDTH`: signed result.
- `y_valid` out 1 / `y_ready` in 1: output handshake.

## Operation
- States are LOAD_F, LOAD_X, COMPUTE and OUTPUT.
- **LOAD_F**
  - `f_ready=1`, `x_ready=0`.
  - Each f handshake stores `f_data` at `f[f_cnt]`, where `f_cnt` runs 0..F-1.
  - The handshake with `f_cnt==F-1` moves to LOAD_X.
- **LOAD_X**
  - `x_ready=1`, `f_ready=0`.
  - Each x handshake stores the sample at `x[x_cnt]`, where `x_cnt` runs 0..X-1.
  - The handshake with `x_cnt==X-1` moves to COMPUTE with output index `j=0`.
- **COMPUTE**
  - Issues reads of `x[j*STRIDE+k]` and `f[k]` for k=0..F-1, one tap per cycle.
  - The memory read has 1 cycle of latency, followed by a product register.
  - The accumulator is cleared on COMPUTE entry.
  - The block moves to OUTPUT after the final accumulate.
- **OUTPUT**
  - `y_valid=1`.
  - On a y handshake: if `j<N-1`, set `j++` and return to COMPUTE. Otherwise the frame is done.
  - At frame done, go to LOAD_F if `f_valid==1` in the handshake cycle; otherwise go to LOAD_X and keep the current filter.
- **Arithmetic**
  - The product is a full 2·WIDTH signed value, saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - The accumulator sum is computed at WIDTH+1 bits and saturated to the same range.
- **Input gating**
  - `x_valid` is ignored outside LOAD_X.
  - `f_valid` is ignored outside LOAD_F, except for the frame-done decision.
- **Reset**
  - Reset at any time returns to LOAD_F and zeroes all counters, the accumulator and the pipeline register.
  - Filter contents are treated as invalid, so a full reload is required.

## Timing
- **Reset values:** `f_ready=1`, `x_ready=0`, `y_valid=0`, `y_data=0`.
- **First-output latency:** if the last x handshake occurs at edge e, `y_valid` is high after edge e+F+2.
- **Inter-output latency:** if a y handshake (not the last) occurs at edge h, the next `y_valid` is high after edge h+F+3.
- **Throughput:** one tap per cycle; no x or f acceptance during COMPUTE or OUTPUT.
- **Backpressure:** while `y_valid && !y_ready`, `y_data` and `y_valid` are held stable.
- **Handshake outputs:** `x_ready`, `f_ready` and `y_valid` are decoded from state only, with no combinational path from `*_valid` or `y_ready`.
- **Last x and first output:** the last x handshake and the first-output start never overlap. LOAD_X exits on the edge that captures the last sample.

## Configuration
- Macro: `CONV1D_RELU_EN`.
- When defined, `y_data = (acc < 0) ? 0 : acc`.
- When undefined, `y_data` is the raw saturated signed accumulator.

## Test plan
All scenarios use `WIDTH=16`, `X=8`, `F=3`, `STRIDE=1` unless stated otherwise.
- **Basic:** load filter {1,2,3}, stream x=0..7 with `y_ready=1` → y = 8,14,20,26,32,38; the first `y_valid` appears 5 cycles after the last x edge.
- **Saturation:** filter {32767,32767,32767}, x all 2 → every y = 32767. Filter {−32768,−32768,−32768}, x all 2, `CONV1D_RELU_EN` undefined → every y = −32768.
- **ReLU:** filter {−1,0,0}, x all 5 → y = 0 with `CONV1D_RELU_EN`; y = −5 without it.
- **Stride:** `F=2`, `STRIDE=2`, filter {1,1}, x=0..7 → N=4, y = 1,5,9,13.
- **Backpressure and filter reload:**
  - Hold `y_ready` low for 10 cycles on output 2 → `y_data` is stable and no output is lost.
  - Assert `f_valid` during the last y handshake → the FSM enters LOAD_F.
  - After loading the new filter {1,0,0}, x=0..7 → y = 0..5.
  - A second frame sent without `f_valid` reuses the stored filter.
- **Reset mid-COMPUTE:** assert `reset` → `y_valid=0` and `f_ready=1` immediately. `x_valid` is then ignored until F coefficients have been loaded.

Source files
------------

// File: rtl/conv1d_stream_param.sv
// conv1d_stream_param: streaming 1-D convolution with run-time filter load.
// Parameters: WIDTH (data/coef width), X (input length), F (filter length),
// STRIDE (output step). Produces N = (X-F)/STRIDE + 1 outputs per frame.
// Optional build macro CONV1D_RELU_EN clamps negative results to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD_F  | accepting F filter coefficients
// LOAD_X  | accepting X input samples
// COMPUTE | one tap per cycle through read -> product -> accumulate
// OUTPUT  | presenting y_data, waiting for the consumer
module conv1d_stream_param #(
  parameter int WIDTH  = 16,
  parameter int X      = 32,
  parameter int F      = 6,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] f_data,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [WIDTH-1:0] x_data,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int N  = (X - F) / STRIDE + 1;
  localparam int XW = $clog2(X);
  localparam int FW = $clog2(F);
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(F + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(X - 1);
  localparam logic [FW-1:0] F_LAST    = FW'(F - 1);
  localparam logic [JW-1:0] J_LAST    = JW'(N - 1);
  localparam logic [CW-1:0] TAPS      = CW'(F);
  localparam logic [CW-1:0] ONE_TAP   = CW'(1);
  localparam logic [XW-1:0] BASE_STEP = XW'(STRIDE);

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] LOAD_F  = 2'd0;
  localparam logic [1:0] LOAD_X  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] OUTPUT  = 2'd3;

  logic [1:0]              state;
  logic [FW-1:0]           f_cnt;
  logic [XW-1:0]           x_cnt;
  logic [JW-1:0]           j;
  logic [XW-1:0]           base;
  logic                    bubble;
  logic [CW-1:0]           rd_left;
  logic [CW-1:0]           acc_left;
  logic [FW-1:0]           rd_k;
  logic                    rd_v;
  logic                    prod_v;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] f_q;
  logic signed [WIDTH-1:0] prod;
  logic signed [WIDTH-1:0] acc;

  logic signed [WIDTH-1:0] f_mem [0:F-1];
  logic signed [WIDTH-1:0] x_mem [0:X-1];

  logic                      f_hs;
  logic                      x_hs;
  logic                      y_hs;
  logic                      x_last_hs;
  logic                      next_window;
  logic                      issue;
  logic                      last_acc;
  logic [XW-1:0]             rd_addr;
  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [WIDTH-1:0]   prod_sat;
  logic signed [WIDTH-1:0]   acc_sum;

  // Clamp a full-width product into the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] sat_mul(input logic signed [2*WIDTH-1:0] p);
    logic [WIDTH:0] top;
    top = p[2*WIDTH-1:WIDTH-1];
    if ((&top) || !(|top)) return p[WIDTH-1:0];
    else if (p[2*WIDTH-1]) return S_MIN;
    else return S_MAX;
  endfunction

  // WIDTH+1 bit add; overflow shows up as the two top bits disagreeing.
  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? S_MIN : S_MAX;
    else return s[WIDTH-1:0];
  endfunction

  assign f_ready = (state == LOAD_F);
  assign x_ready = (state == LOAD_X);
  assign y_valid = (state == OUTPUT);

  assign f_hs = f_ready & f_valid;
  assign x_hs = x_ready & x_valid;
  assign y_hs = y_valid & y_ready;

  assign x_last_hs   = x_hs && (x_cnt == X_LAST);
  assign next_window = y_hs && (j != J_LAST);

  assign issue    = (state == COMPUTE) && !bubble && (rd_left != '0);
  assign last_acc = (state == COMPUTE) && prod_v && (acc_left == ONE_TAP);
  assign rd_addr  = base + XW'(rd_k);

  assign prod_full = $signed({{WIDTH{x_q[WIDTH-1]}}, x_q}) * $signed({{WIDTH{f_q[WIDTH-1]}}, f_q});
  assign prod_sat  = sat_mul(prod_full);
  assign acc_sum   = sat_add(acc, prod);

`ifdef CONV1D_RELU_EN
  assign y_data = acc[WIDTH-1] ? '0 : acc;
`else
  assign y_data = acc;
`endif

  // Sequencing: load counters, window index/base and tap down-counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOAD_F;
      f_cnt    <= '0;
      x_cnt    <= '0;
      j        <= '0;
      base     <= '0;
      bubble   <= 1'b0;
      rd_left  <= '0;
      rd_k     <= '0;
      acc_left <= '0;
    end else begin
      case (state)
        LOAD_F: begin
          if (f_hs) begin
            if (f_cnt == F_LAST) begin
              f_cnt <= '0;
              x_cnt <= '0;
              state <= LOAD_X;
            end else begin
              f_cnt <= f_cnt + FW'(1);
            end
          end
        end
        LOAD_X: begin
          if (x_hs) begin
            if (x_cnt == X_LAST) begin
              x_cnt    <= '0;
              j        <= '0;
              base     <= '0;
              bubble   <= 1'b0;
              rd_left  <= TAPS;
              rd_k     <= '0;
              acc_left <= TAPS;
              state    <= COMPUTE;
            end else begin
              x_cnt <= x_cnt + XW'(1);
            end
          end
        end
        COMPUTE: begin
          // The bubble cycle advances the window base by one stride
          // before the first read of the new window is issued.
          if (bubble) begin
            bubble <= 1'b0;
            base   <= base + BASE_STEP;
          end else if (rd_left != '0) begin
            rd_left <= rd_left - ONE_TAP;
            rd_k    <= rd_k + FW'(1);
          end
          if (prod_v) acc_left <= acc_left - ONE_TAP;
          if (last_acc) state <= OUTPUT;
        end
        OUTPUT: begin
          if (y_hs) begin
            if (j == J_LAST) begin
              if (f_valid) begin
                f_cnt <= '0;
                state <= LOAD_F;
              end else begin
                x_cnt <= '0;
                state <= LOAD_X;
              end
            end else begin
              j        <= j + JW'(1);
              bubble   <= 1'b1;
              rd_left  <= TAPS;
              rd_k     <= '0;
              acc_left <= TAPS;
              state    <= COMPUTE;
            end
          end
        end
        default: state <= LOAD_F;
      endcase
    end
  end

  // Coefficient and sample storage; contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (f_hs) f_mem[f_cnt] <= f_data;
    if (x_hs) x_mem[x_cnt] <= x_data;
  end

  // Tap pipeline: registered read, saturated product, saturated accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      f_q    <= '0;
      rd_v   <= 1'b0;
      prod   <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      rd_v <= issue;
      if (issue) begin
        x_q <= x_mem[rd_addr];
        f_q <= f_mem[rd_k];
      end
      prod_v <= rd_v;
      if (rd_v) prod <= prod_sat;
      if (x_last_hs || next_window) acc <= '0;
      else if (prod_v) acc <= acc_sum;
    end
  end

endmodule

// File: tb/tb_conv1d_stream_param.sv
// Testbench for conv1d_stream_param: table-driven frames, random frames
// against an arithmetic reference model, stride, backpressure and reset.
module tb_conv1d_stream_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] a_f_data, a_x_data, a_y_data;
  logic a_f_valid, a_f_ready, a_x_valid, a_x_ready, a_y_valid, a_y_ready;
  logic [15:0] b_f_data, b_x_data, b_y_data;
  logic b_f_valid, b_f_ready, b_x_valid, b_x_ready, b_y_valid, b_y_ready;

  conv1d_stream_param #(.WIDTH(16), .X(8), .F(3), .STRIDE(1)) dut_a (
    .clk(clk), .reset(rst),
    .f_data(a_f_data), .f_valid(a_f_valid), .f_ready(a_f_ready),
    .x_data(a_x_data), .x_valid(a_x_valid), .x_ready(a_x_ready),
    .y_data(a_y_data), .y_valid(a_y_valid), .y_ready(a_y_ready)
  );

  conv1d_stream_param #(.WIDTH(16), .X(8), .F(2), .STRIDE(2)) dut_b (
    .clk(clk), .reset(rst),
    .f_data(b_f_data), .f_valid(b_f_valid), .f_ready(b_f_ready),
    .x_data(b_x_data), .x_valid(b_x_valid), .x_ready(b_x_ready),
    .y_data(b_y_data), .y_valid(b_y_valid), .y_ready(b_y_ready)
  );

  typedef struct packed {
    logic [2:0][15:0] f;
    logic [7:0][15:0] x;
    logic [5:0][15:0] y;
    logic             rel;
    logic signed [7:0] hold;
  } vec_t;

  vec_t vt [0:4];
  int total = 0;
  int bad = 0;
  int last_evt = 0;
  int mf [0:7];
  int mx [0:7];
  int ey [0:7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int relu(input int v);
`ifdef CONV1D_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Window j: products clamped, running sum clamped after every tap.
  function automatic int ref_y(input int j, input int stride, input int flen);
    longint s = 0;
    for (int k = 0; k < flen; k++)
      s = sat16(s + sat16(longint'(mx[j*stride+k]) * longint'(mf[k])));
    return relu(int'(s));
  endfunction

  task automatic load_f();
    for (int i = 0; i < 3; i++) begin
      int w = 0;
      a_f_data = 16'(mf[i]);
      a_f_valid = 1'b1;
      while (!a_f_ready && w < 20) begin @(posedge clk); #1; w++; end
      if (w == 20) chk("f_ready wait", 0, 1);
      @(posedge clk); #1;
    end
    a_f_valid = 1'b0;
  endtask

  task automatic send_x();
    for (int i = 0; i < 8; i++) begin
      int w = 0;
      a_x_data = 16'(mx[i]);
      a_x_valid = 1'b1;
      while (!a_x_ready && w < 20) begin @(posedge clk); #1; w++; end
      if (w == 20) chk("x_ready wait", 0, 1);
      @(posedge clk); #1;
    end
    a_x_valid = 1'b0;
    last_evt = cyc;
  endtask

  task automatic recv(input string nm, input int hold_idx, input bit fv_last);
    for (int i = 0; i < 6; i++) begin
      int w = 0;
      while (!a_y_valid && w < 40) begin @(posedge clk); #1; w++; end
      if (w == 40) begin
        chk($sformatf("%s y%0d valid timeout", nm, i), 0, 1);
        return;
      end
      chk($sformatf("%s latency y%0d", nm, i), cyc - last_evt, (i == 0) ? 5 : 6);
      if (i == hold_idx) begin
        a_y_ready = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          chk($sformatf("%s hold valid", nm), a_y_valid, 1);
          chk($sformatf("%s hold data", nm), $signed(a_y_data), ey[i]);
        end
        a_y_ready = 1'b1;
      end
      chk($sformatf("%s y%0d", nm, i), $signed(a_y_data), ey[i]);
      if (i == 5) a_f_valid = fv_last;
      @(posedge clk); #1;
      last_evt = cyc;
      a_f_valid = 1'b0;
    end
    chk($sformatf("%s f_ready after frame", nm), a_f_ready, fv_last);
    chk($sformatf("%s x_ready after frame", nm), a_x_ready, !fv_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit need_f;
    logic signed [15:0] t;
    int mode;

    for (int v = 0; v < 5; v++) begin
      vt[v].rel = 1'b1;
      vt[v].hold = -8'sd1;
    end
    for (int k = 0; k < 3; k++) begin
      vt[0].f[k] = 16'(k + 1);
      vt[1].f[k] = 16'(32767);
      vt[2].f[k] = 16'(-32768);
      vt[3].f[k] = (k == 0) ? 16'(-1) : 16'(0);
      vt[4].f[k] = (k == 0) ? 16'(1) : 16'(0);
    end
    for (int k = 0; k < 8; k++) begin
      vt[0].x[k] = 16'(k);
      vt[1].x[k] = 16'(2);
      vt[2].x[k] = 16'(2);
      vt[3].x[k] = 16'(5);
      vt[4].x[k] = 16'(k);
    end
    for (int jj = 0; jj < 6; jj++) begin
      vt[0].y[jj] = 16'(8 + 6 * jj);
      vt[1].y[jj] = 16'(32767);
      vt[2].y[jj] = 16'(-32768);
      vt[3].y[jj] = 16'(-5);
      vt[4].y[jj] = 16'(jj);
    end
    vt[0].hold = 8'sd2;
    vt[4].rel = 1'b0;

    a_f_data = '0; a_f_valid = 0; a_x_data = '0; a_x_valid = 0; a_y_ready = 1;
    b_f_data = '0; b_f_valid = 0; b_x_data = '0; b_x_valid = 0; b_y_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("reset f_ready", a_f_ready, 1);
    chk("reset x_ready", a_x_ready, 0);
    chk("reset y_valid", a_y_valid, 0);
    chk("reset y_data", a_y_data, 0);

    // Stride instance: F=2, STRIDE=2, filter {1,1}, x=0..7.
    chk("stride f_ready", b_f_ready, 1);
    for (int i = 0; i < 2; i++) begin
      b_f_data = 16'd1; b_f_valid = 1'b1;
      @(posedge clk); #1;
    end
    b_f_valid = 1'b0;
    chk("stride x_ready", b_x_ready, 1);
    for (int i = 0; i < 8; i++) begin
      b_x_data = 16'(i); b_x_valid = 1'b1;
      @(posedge clk); #1;
    end
    b_x_valid = 1'b0;
    for (int jj = 0; jj < 4; jj++) begin
      int w = 0;
      while (!b_y_valid && w < 40) begin @(posedge clk); #1; w++; end
      chk($sformatf("stride y%0d", jj), $signed(b_y_data), 1 + 4 * jj);
      @(posedge clk); #1;
    end
    chk("stride x_ready after frame", b_x_ready, 1);

    // Table frames.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 3; k++) mf[k] = int'($signed(vt[v].f[k]));
      for (int k = 0; k < 8; k++) mx[k] = int'($signed(vt[v].x[k]));
      for (int jj = 0; jj < 6; jj++) ey[jj] = relu(int'($signed(vt[v].y[jj])));
      load_f();
      send_x();
      recv($sformatf("vec%0d", v), int'(vt[v].hold), vt[v].rel);
    end

    // Second frame reusing the stored {1,0,0} filter.
    for (int k = 0; k < 8; k++) mx[k] = 7 - k;
    for (int jj = 0; jj < 6; jj++) ey[jj] = 7 - jj;
    send_x();
    recv("reuse", -1, 1'b0);

    // Random frames with random filter reloads.
    need_f = 1'b0;
    for (int r = 0; r < 8; r++) begin
      bit nxt;
      mode = $urandom_range(0, 2);
      if (need_f) begin
        for (int k = 0; k < 3; k++) begin
          t = 16'($urandom);
          mf[k] = (mode == 0) ? int'($urandom_range(0, 16)) - 8 : int'(t);
        end
        load_f();
      end
      for (int k = 0; k < 8; k++) begin
        t = 16'($urandom);
        mx[k] = (mode == 2) ? int'(t) : int'($urandom_range(0, 200)) - 100;
      end
      for (int jj = 0; jj < 6; jj++) ey[jj] = ref_y(jj, 1, 3);
      send_x();
      nxt = 1'($urandom_range(0, 1));
      recv($sformatf("rand%0d", r), -1, nxt);
      need_f = nxt;
    end

    // Reset during COMPUTE.
    if (need_f) begin
      mf[0] = 1; mf[1] = 2; mf[2] = 3;
      load_f();
    end
    for (int k = 0; k < 8; k++) mx[k] = k;
    send_x();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midreset y_valid", a_y_valid, 0);
    chk("midreset f_ready", a_f_ready, 1);
    chk("midreset x_ready", a_x_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_x_data = 16'd99; a_x_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post-reset x_ready", a_x_ready, 0);
    mf[0] = 1; mf[1] = 0; mf[2] = 0;
    for (int i = 0; i < 2; i++) begin
      a_f_data = 16'(mf[i]); a_f_valid = 1'b1;
      @(posedge clk); #1;
    end
    a_f_valid = 1'b0;
    chk("partial filter x_ready", a_x_ready, 0);
    a_x_valid = 1'b0;
    a_f_data = 16'(mf[2]); a_f_valid = 1'b1;
    @(posedge clk); #1;
    a_f_valid = 1'b0;
    chk("reloaded x_ready", a_x_ready, 1);
    for (int k = 0; k < 8; k++) mx[k] = k;
    for (int jj = 0; jj < 6; jj++) ey[jj] = jj;
    send_x();
    recv("after reset", -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
